// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and constants for the FIFO read-side packer.
package fifo_pack_pkg;

  // Packer FSM states: gather entries, then hold a finished word for downstream.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } pack_state_e;

  localparam int DEF_DSIZE  = 8;
  localparam int DEF_PACK_N = 4;

  // out_cnt must represent 1..PACK_N, so it needs one bit above the lane index.
  function automatic int cnt_width(input int pack_n);
    return $clog2(pack_n) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bus bundle between the async FIFO read port, the packer and its consumer.
// master: the packer side; slave: the FIFO/consumer environment side.
interface fifo_rd_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int DSIZE  = DEF_DSIZE,
  parameter int PACK_N = DEF_PACK_N
);

  logic                           rd_empty;
  logic [DSIZE-1:0]               fifo_data;
  logic                           rd_inc;
  logic                           flush;
  logic [DSIZE*PACK_N-1:0]        out_data;
  logic [cnt_width(PACK_N)-1:0]   out_cnt;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    input  rd_empty, fifo_data, flush, out_ready,
    output rd_inc, out_data, out_cnt, out_valid
  );

  modport slave (
    output rd_empty, fifo_data, flush, out_ready,
    input  rd_inc, out_data, out_cnt, out_valid
  );

endinterface

// File: rtl/fifo_rd_packer_lane_ctr.sv
// Lane index counter for the packer: increments per stored entry, clears
// when a word is emitted, flags the last lane.
module fifo_pack_lane_ctr #(
  parameter int PACK_N = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inc_i,
  input  logic                      clr_i,
  output logic [$clog2(PACK_N)-1:0] idx_o,
  output logic                      tc_o
);

  localparam int IW = $clog2(PACK_N);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  // Next index: clear wins over increment so a terminal pop restarts at lane 0.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // Index register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;
  assign tc_o  = (idx_q == IW'(PACK_N - 1));

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: pops DSIZE-bit entries from a first-word-fall-through
// FIFO, packs PACK_N of them into one word and offers it on valid/ready.
// A flush pulse emits a partially filled word; unused lanes read 0.
// Build option: FIFO_RD_PACKER_MSB_FIRST_EN places the first entry in the
// most-significant lane (left-aligned partial words); default is LSB-first.
// PACK_N must be a power of two between 2 and 16.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DSIZE  = DEF_DSIZE,
  parameter int PACK_N = DEF_PACK_N
) (
  input  logic              rd_clk,
  input  logic              r_rst,
  fifo_rd_packer_if.master  bus
);

  localparam int OSIZE = DSIZE * PACK_N;
  localparam int IW    = $clog2(PACK_N);
  localparam int CW    = cnt_width(PACK_N);

  pack_state_e                    state_q;
  pack_state_e                    state_d;
  logic [PACK_N-1:0][DSIZE-1:0]   lanes_q;
  logic [PACK_N-1:0][DSIZE-1:0]   lanes_d;
  logic [CW-1:0]                  cnt_q;
  logic [CW-1:0]                  cnt_d;

  logic [IW-1:0]                  idx;
  logic                           idx_tc;
  logic                           ctr_inc;
  logic                           ctr_clr;
  logic [IW-1:0]                  lane_sel;
  logic                           pop;

  // Pop only depends on registered state, FIFO empty and reset, never on
  // out_ready or flush, so the FIFO pop path stays short.
  assign pop = (state_q == COLLECT) && !bus.rd_empty && !r_rst;

`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
  assign lane_sel = IW'(PACK_N - 1) - idx;
`else
  assign lane_sel = idx;
`endif

  fifo_pack_lane_ctr #(
    .PACK_N (PACK_N)
  ) u_lane_ctr (
    .clk_i (rd_clk),
    .rst_i (r_rst),
    .inc_i (ctr_inc),
    .clr_i (ctr_clr),
    .idx_o (idx),
    .tc_o  (idx_tc)
  );

  // Next-state, lane write and count logic for the COLLECT/HOLD FSM.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    ctr_inc = 1'b0;
    ctr_clr = 1'b0;
    case (state_q)
      COLLECT: begin
        if (pop) begin
          lanes_d[lane_sel] = bus.fifo_data;
          if (idx_tc || bus.flush) begin
            // Entry is stored first, then the word closes with idx+1 lanes.
            state_d = HOLD;
            cnt_d   = {1'b0, idx} + CW'(1);
            ctr_clr = 1'b1;
          end else begin
            ctr_inc = 1'b1;
          end
        end else if (bus.flush && (idx != '0)) begin
          state_d = HOLD;
          cnt_d   = {1'b0, idx};
          ctr_clr = 1'b1;
        end
      end
      HOLD: begin
        // Flush is deliberately ignored here; the word waits for out_ready.
        if (bus.out_ready) begin
          state_d = COLLECT;
          lanes_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State, lane and count registers; reset discards any partial or pending word.
  always_ff @(posedge rd_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q <= COLLECT;
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rd_inc    = pop;
  assign bus.out_data  = OSIZE'(lanes_q);
  assign bus.out_cnt   = cnt_q;
  assign bus.out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model feeding the packer, a word-level
// reference model and directed tests plus a random scoreboard phase.
module tb_fifo_rd_packer;

  localparam int DS = 8;
  localparam int PN = 4;
  localparam int OW = DS * PN;

  logic clk = 1'b0;
  logic r_rst;

  fifo_rd_packer_if #(.DSIZE(DS), .PACK_N(PN)) bus ();

  fifo_rd_packer #(.DSIZE(DS), .PACK_N(PN)) dut (
    .rd_clk (clk),
    .r_rst  (r_rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: first-word fall-through array with read/write pointers.
  logic [DS-1:0] mem [256];
  int wptr = 0;
  int rptr = 0;

  assign bus.rd_empty  = (wptr == rptr);
  assign bus.fifo_data = mem[rptr[7:0]];

  always @(posedge clk) begin
    if (bus.rd_inc) rptr <= rptr + 1;
  end

  // Reference model: gather entries while no word is pending; emit when full
  // or on flush with at least one entry; pending word leaves on out_ready.
  logic [DS-1:0] m_cur [16];
  int            m_n = 0;
  bit            m_pending = 1'b0;
  logic [OW-1:0] m_word = '0;
  int            m_cnt = 0;

  function automatic logic [OW-1:0] pack(input logic [DS-1:0] c [16], input int n);
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
      w[(PN-1-i)*DS +: DS] = c[i];
`else
      w[i*DS +: DS] = c[i];
`endif
    end
    return w;
  endfunction

  always @(posedge clk or posedge r_rst) begin
    logic [DS-1:0] cv [16];
    int n;
    if (r_rst) begin
      m_pending <= 1'b0;
      m_n       <= 0;
      m_word    <= '0;
      m_cnt     <= 0;
    end else if (m_pending) begin
      if (bus.out_ready) m_pending <= 1'b0;
    end else begin
      cv = m_cur;
      n  = m_n;
      if (wptr != rptr) begin
        cv[n] = bus.fifo_data;
        n = n + 1;
      end
      if (n == PN || (bus.flush && n > 0)) begin
        m_word    <= pack(cv, n);
        m_cnt     <= n;
        m_pending <= 1'b1;
        m_n       <= 0;
      end else begin
        m_n   <= n;
        m_cur <= cv;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic tick();
    @(negedge clk);
    chk("valid", 64'(bus.out_valid), 64'(m_pending));
    if (m_pending) begin
      chk("data", 64'(bus.out_data), 64'(m_word));
      chk("cnt", 64'(bus.out_cnt), 64'(m_cnt));
    end
    chk("rd_inc", 64'(bus.rd_inc), 64'(!m_pending && (wptr != rptr) && !r_rst));
  endtask

  task automatic push(input logic [DS-1:0] b);
    mem[wptr[7:0]] = b;
    wptr = wptr + 1;
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    bit ok;
    ok  = bus.out_valid;
    cyc = 0;
    while (!ok && cyc < maxc) begin
      tick();
      cyc++;
      ok = bus.out_valid;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no out_valid within %0d cycles", maxc);
    end
  endtask

  logic [OW-1:0] exp1, exp2, exp3, exp4, exp5;
  logic [OW-1:0] cap;
  int cyc;
  int pushed;

  initial begin
`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
    exp1 = 32'h11223344; exp2 = 32'hAABB0000; exp3 = 32'h01020300;
    exp4 = 32'h14151617; exp5 = 32'hA3A4B1B2;
`else
    exp1 = 32'h44332211; exp2 = 32'h0000BBAA; exp3 = 32'h00030201;
    exp4 = 32'h17161514; exp5 = 32'hB2B1A4A3;
`endif
    r_rst         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset state, with the FIFO already holding data.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_cnt", 64'(bus.out_cnt), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_rd_inc", 64'(bus.rd_inc), 64'd0);

    // Full word, back-to-back pops.
    r_rst = 1'b0;
    wait_valid(10, cyc);
    chk("full_latency", 64'(cyc), 64'd4);
    chk("full_data", 64'(bus.out_data), 64'(exp1));
    chk("full_cnt", 64'(bus.out_cnt), 64'd4);
    chk("hold_rd_inc", 64'(bus.rd_inc), 64'd0);
    tick();
    chk("full_one_cycle", 64'(bus.out_valid), 64'd0);

    // Partial word via flush with FIFO empty.
    push(8'hAA); push(8'hBB);
    repeat (3) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_valid(3, cyc);
    chk("part_data", 64'(bus.out_data), 64'(exp2));
    chk("part_cnt", 64'(bus.out_cnt), 64'd2);
    tick();

    // Flush with nothing collected produces nothing.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    chk("empty_flush", 64'(bus.out_valid), 64'd0);

    // Flush coincident with the third pop.
    push(8'h01); push(8'h02);
    repeat (3) tick();
    push(8'h03);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_valid(3, cyc);
    chk("coinc_data", 64'(bus.out_data), 64'(exp3));
    chk("coinc_cnt", 64'(bus.out_cnt), 64'd3);
    tick();

    // Backpressure: word held stable, no pops while stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    wait_valid(10, cyc);
    cap = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_data", 64'(bus.out_data), 64'(cap));
      chk("stall_rd_inc", 64'(bus.rd_inc), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    wait_valid(10, cyc);
    chk("after_stall_data", 64'(bus.out_data), 64'(exp4));
    chk("after_stall_cnt", 64'(bus.out_cnt), 64'd4);
    tick();

    // Asynchronous reset after two pops.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    tick();
    tick();
    r_rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_rd_inc", 64'(bus.rd_inc), 64'd0);
    chk("arst_data", 64'(bus.out_data), 64'd0);
    tick();
    r_rst = 1'b0;
    push(8'hB1); push(8'hB2);
    wait_valid(10, cyc);
    chk("post_rst_data", 64'(bus.out_data), 64'(exp5));
    tick();

    // Random traffic against the model.
    pushed = 0;
    for (int i = 0; i < 2000; i++) begin
      if (pushed < 60 && ($urandom % 3) != 0) begin
        push(8'($urandom));
        pushed++;
      end
      bus.out_ready = 1'($urandom % 2);
      bus.flush     = (($urandom % 10) == 0);
      tick();
      if (pushed == 60 && wptr == rptr && !bus.out_valid) break;
    end
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    tick();
    tick();
    chk("drain_fifo_empty", 64'(bus.rd_empty), 64'd1);
    chk("drain_idle", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
